count_seq_monitor: RTL
======================

Name: count_seq_monitor

Overview:
- Downstream consumer of the 3-bit T-flip-flop ripple counter; samples its count bus in the same clk domain.
- Checks that the count advances by exactly +1 (mod 2^WIDTH) per sample and locks onto the sequence after LOCK_CNT consecutive good steps.
- Once locked, flags sequence errors and counts wrap-arounds (max->0) for the rest of the datapath.

Parameters:
- WIDTH, 3, width of monitored count bus
- LOCK_CNT, 4, consecutive correct steps required to enter LOCKED (legal range 1..15)
- WRAP_W, 8, width of wrap counter

Ports:
- clk  input  1  system clock, all state updates on posedge
- reset  input  1  asynchronous, active-high; clears all state
- count_in  input  WIDTH  count value from upstream counter
- sample_en  input  1  sample count_in on this clk edge when 1
- clear  input  1  synchronous clear of FSM, wrap_count and error state
- locked  output  1  high while FSM in LOCKED
- seq_err  output  1  error indication (pulse or sticky, see Optional Feature)
- wrap_pulse  output  1  one-cycle pulse on a detected wrap while locked
- wrap_count  output  WRAP_W  number of wraps seen since reset/clear, saturating
- last_count  output  WIDTH  most recent sampled value

Behaviour:
- Reset (async):
  - state=IDLE, match_cnt=0, prev=0.
  - last_count=0, locked=0, seq_err=0, wrap_pulse=0, wrap_count=0.
- All outputs are registered; the effect of a sample is visible the cycle after the sampling edge (latency 1).
- exp = prev+1 truncated to WIDTH bits, so max (2^WIDTH-1) +1 = 0.
- Every accepted sample (sample_en=1, clear=0): prev<=count_in, last_count<=count_in.
- wrap_pulse defaults to 0 each cycle. Non-sticky seq_err also defaults to 0 each cycle.
- FSM states: IDLE, TRACK, LOCKED.
  - IDLE: on a sample, go to TRACK with match_cnt=0. No comparison is made.
  - TRACK:
    - On a sample equal to exp: match_cnt+1. When the new value equals LOCK_CNT, go to LOCKED and clear match_cnt.
    - On a mismatch: match_cnt=0 and stay in TRACK. No seq_err is raised in TRACK.
  - LOCKED:
    - On a sample equal to exp: stay in LOCKED. If prev was max and the sample is 0, pulse wrap_pulse and increment wrap_count.
    - On a mismatch: assert seq_err, go to TRACK with match_cnt=0, and deassert locked the next cycle.
- wrap_count saturates at all-ones and does not wrap.
- sample_en=0: all state holds; wrap_pulse=0; non-sticky seq_err=0.
- Held value (sample equals prev) is a mismatch.
- clear=1 has priority over sample_en:
  - state=IDLE, match_cnt=0, wrap_count=0, seq_err=0, wrap_pulse=0.
  - prev and last_count are retained.
- LOCK_CNT=1: a single correct step from TRACK locks.
- Reset mid-operation: all state returns to reset values immediately, regardless of clk.

Optional Feature:
- Macro: COUNT_SEQ_MONITOR_STICKY_ERR_EN.
- Defined: seq_err is sticky. It sets on the first LOCKED mismatch and stays high until clear or reset. Later relocking does not clear it.
- Undefined: seq_err is a one-cycle pulse per LOCKED mismatch.
- FSM behaviour is identical in both builds.

Test Plan:
- Reset, then sample_en=1 with count_in 0,1,2,3,4 on consecutive edges -> locked=1 in the cycle after the edge sampling 4; seq_err=0 throughout; last_count=4.
- Locked with count sequence ...6,7,0,1 -> wrap_pulse=1 for exactly one cycle after the edge sampling 0; wrap_count 0->1.
- Locked at prev=2, then sample 5 -> seq_err=1 for one cycle (non-sticky) and locked=0 next cycle. With COUNT_SEQ_MONITOR_STICKY_ERR_EN, seq_err stays 1 through relock on 6,7,0,1 until clear=1.
- Locked, then drop sample_en for 3 cycles while count_in changes, then resume with 3,4 after last sample 2 -> no error, state held, locked stays 1.
- Drive 300 continuous wraps with WRAP_W=8 -> wrap_count saturates at 255. Then clear=1 with sample_en=1 -> wrap_count=0, locked=0, FSM in IDLE, last_count unchanged.
- Assert reset asynchronously between edges while locked with wrap_count=5 -> all outputs 0 immediately. After release, the 0..4 sequence relocks.

Source files
------------

// File: rtl/count_seq_monitor.sv
// Sequence monitor for an upstream modulo-2^WIDTH counter: locks after LOCK_CNT good steps,
// then flags sequence errors and counts wraps. COUNT_SEQ_MONITOR_STICKY_ERR_EN makes seq_err sticky.
module count_seq_monitor #(
    parameter int unsigned WIDTH    = 3,
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned WRAP_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  count_in,
    input  logic              sample_en,
    input  logic              clear,
    output logic              locked,
    output logic              seq_err,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_count,
    output logic [WIDTH-1:0]  last_count
);

    localparam int unsigned MATCH_W = 4;

`ifdef COUNT_SEQ_MONITOR_STICKY_ERR_EN
    localparam bit STICKY_ERR = 1'b1;
`else
    localparam bit STICKY_ERR = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_TRACK  = 2'd1,
        S_LOCKED = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [MATCH_W-1:0]  match_q, match_d;
    logic [WIDTH-1:0]    prev_q, prev_d;
    logic [WIDTH-1:0]    last_q, last_d;
    logic                locked_q, locked_d;
    logic                seq_err_q, seq_err_d;
    logic                wrap_pulse_q, wrap_pulse_d;
    logic [WRAP_W-1:0]   wrap_cnt_q, wrap_cnt_d;

    logic [WIDTH-1:0]    exp_c;
    logic [MATCH_W-1:0]  match_inc_c;
    logic                hit_c;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            match_q      <= '0;
            prev_q       <= '0;
            last_q       <= '0;
            locked_q     <= 1'b0;
            seq_err_q    <= 1'b0;
            wrap_pulse_q <= 1'b0;
            wrap_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            match_q      <= match_d;
            prev_q       <= prev_d;
            last_q       <= last_d;
            locked_q     <= locked_d;
            seq_err_q    <= seq_err_d;
            wrap_pulse_q <= wrap_pulse_d;
            wrap_cnt_q   <= wrap_cnt_d;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d      = state_q;
        match_d      = match_q;
        prev_d       = prev_q;
        last_d       = last_q;
        wrap_pulse_d = 1'b0;
        seq_err_d    = STICKY_ERR ? seq_err_q : 1'b0;
        wrap_cnt_d   = wrap_cnt_q;

        exp_c       = prev_q + WIDTH'(1);
        match_inc_c = match_q + MATCH_W'(1);
        hit_c       = (count_in == exp_c);

        if (clear) begin
            state_d    = S_IDLE;
            match_d    = '0;
            wrap_cnt_d = '0;
            seq_err_d  = 1'b0;
        end else if (sample_en) begin
            prev_d = count_in;
            last_d = count_in;
            unique case (state_q)
                S_IDLE: begin
                    state_d = S_TRACK;
                    match_d = '0;
                end
                S_TRACK: begin
                    if (hit_c) begin
                        if (match_inc_c == MATCH_W'(LOCK_CNT)) begin
                            state_d = S_LOCKED;
                            match_d = '0;
                        end else begin
                            match_d = match_inc_c;
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                S_LOCKED: begin
                    if (hit_c) begin
                        // A good step onto zero can only come from max: that is a wrap
                        if (count_in == '0) begin
                            wrap_pulse_d = 1'b1;
                            if (wrap_cnt_q != {WRAP_W{1'b1}}) begin
                                wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
                            end
                        end
                    end else begin
                        seq_err_d = 1'b1;
                        state_d   = S_TRACK;
                        match_d   = '0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    match_d = '0;
                end
            endcase
        end

        locked_d = (state_d == S_LOCKED);
    end

    assign locked     = locked_q;
    assign seq_err    = seq_err_q;
    assign wrap_pulse = wrap_pulse_q;
    assign wrap_count = wrap_cnt_q;
    assign last_count = last_q;

endmodule
